// File: rtl/taillight_seq_ctrl.sv
// Taillight sequencer: N lamps per side stepping at a prescaled rate, with
// brake-with-turn, hazard flash, request-conflict resolution and a mode status output.
module taillight_seq_ctrl #(
  parameter int N_LAMPS = 3,
  parameter int DIV     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   left,
  input  logic                   right,
  input  logic                   bk,
  input  logic                   haz,
  output logic [2*N_LAMPS-1:0]   led,
  output logic [2:0]             mode
);

  localparam int SW = $clog2(N_LAMPS + 1);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SW-1:0] STEP_TURN_MAX = SW'(N_LAMPS);
  localparam logic [SW-1:0] STEP_HAZ_MAX  = SW'(1);
  localparam logic [PW-1:0] PRESC_MAX     = PW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LEFT      = 3'd1,
    RIGHT     = 3'd2,
    HAZ       = 3'd3,
    BRAKE     = 3'd4,
    LEFT_BRK  = 3'd5,
    RIGHT_BRK = 3'd6
  } mode_t;

  mode_t                 mode_reg;
  mode_t                 mode_dec;
  logic [PW-1:0]         presc_reg, presc_next;
  logic [SW-1:0]         step_reg, step_next, step_max;
  logic [2*N_LAMPS-1:0]  led_reg, led_next;
  logic [N_LAMPS-1:0]    left_seq, right_seq;
  logic                  tick;

  always_comb begin
    mode_dec = IDLE;
    if (haz || (left && right)) mode_dec = HAZ;
    else if (left && bk)        mode_dec = LEFT_BRK;
    else if (right && bk)       mode_dec = RIGHT_BRK;
    else if (bk)                mode_dec = BRAKE;
    else if (left)              mode_dec = LEFT;
    else if (right)             mode_dec = RIGHT;
  end

  // A mode change restarts the sequence; otherwise the step advances on tick.
  // The >= comparisons keep an out-of-range counter from running past its terminal.
  always_comb begin
    presc_next = presc_reg;
    step_next  = step_reg;
    tick       = (presc_reg >= PRESC_MAX);
    step_max   = (mode_reg == HAZ) ? STEP_HAZ_MAX : STEP_TURN_MAX;
    if (mode_dec != mode_reg) begin
      presc_next = '0;
      step_next  = '0;
    end else if (tick) begin
      presc_next = '0;
      step_next  = (step_reg >= step_max) ? '0 : step_reg + SW'(1);
    end else begin
      presc_next = presc_reg + PW'(1);
    end
  end

  // Lamp gi counts outward from the centre on each side.
  generate
    for (genvar gi = 0; gi < N_LAMPS; gi++) begin : g_lamp
      assign left_seq[gi]             = (step_next > SW'(gi));
      assign right_seq[N_LAMPS-1-gi]  = (step_next > SW'(gi));
    end
  endgenerate

  always_comb begin
    led_next = '0;
    case (mode_dec)
      LEFT:      led_next = {left_seq, {N_LAMPS{1'b0}}};
      RIGHT:     led_next = {{N_LAMPS{1'b0}}, right_seq};
      LEFT_BRK:  led_next = {left_seq, {N_LAMPS{1'b1}}};
      RIGHT_BRK: led_next = {{N_LAMPS{1'b1}}, right_seq};
      BRAKE:     led_next = '1;
      HAZ:       led_next = step_next[0] ? '0 : '1;
      default:   led_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_reg  <= IDLE;
      presc_reg <= '0;
      step_reg  <= '0;
      led_reg   <= '0;
    end else begin
      mode_reg  <= mode_dec;
      presc_reg <= presc_next;
      step_reg  <= step_next;
      led_reg   <= led_next;
    end
  end

  assign led  = led_reg;
  assign mode = mode_reg;

endmodule
